// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: shared types and defaults for the VGA receive path.
//   rx_state_t      - lock FSM states
//   geom_t          - frame geometry bundle at the default coordinate width
//   COORD_W_DEFAULT - default width of coordinate and measurement counters
package vga_rx_pkg;
   localparam int COORD_W_DEFAULT = 11;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } rx_state_t;

   typedef struct packed {
      logic [COORD_W_DEFAULT-1:0] h_total;
      logic [COORD_W_DEFAULT-1:0] h_active;
      logic [COORD_W_DEFAULT-1:0] v_total;
      logic [COORD_W_DEFAULT-1:0] v_active;
   } geom_t;
endpackage

// File: rtl/vga_rx_counters.sv
// vga_rx_counters: input register, sync polarity normalisation, edge detect
// and the timing counters of the VGA receiver.
//   vga_clk, reset        - clock, synchronous active-high reset
//   i_blank_n/i_hs/i_vs   - raw VGA controls
//   i_rgb                 - raw {red, green, blue}
//   o_blank, o_rgb        - stage-1 blank_n and colour
//   o_hs_edge, o_vs_edge  - sync assertion edges (stage 1)
//   o_x, o_y              - coordinate of the current stage-1 pixel
//   o_*_meas              - measurements as they stand after this cycle's edges
//   o_line_err            - a line length changed within the current frame
//   o_wdog                - h counter saturated with no HS edge in sight
module vga_rx_counters
   import vga_rx_pkg::*;
#(
   parameter int COORD_W       = COORD_W_DEFAULT,
   parameter bit HS_ACTIVE_LOW = 1'b1,
   parameter bit VS_ACTIVE_LOW = 1'b1
) (
   input  logic               vga_clk,
   input  logic               reset,
   input  logic               i_blank_n,
   input  logic               i_hs,
   input  logic               i_vs,
   input  logic [23:0]        i_rgb,
   output logic               o_blank,
   output logic [23:0]        o_rgb,
   output logic               o_hs_edge,
   output logic               o_vs_edge,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y,
   output logic [COORD_W-1:0] o_h_meas,
   output logic [COORD_W-1:0] o_ha_meas,
   output logic [COORD_W-1:0] o_v_meas,
   output logic [COORD_W-1:0] o_va_meas,
   output logic               o_line_err,
   output logic               o_wdog
);
   localparam logic [COORD_W-1:0] C_ONE = {{(COORD_W-1){1'b0}}, 1'b1};

   logic               r_hs_a, r_vs_a, r_blank, r_hs_d, r_vs_d, r_blank_d;
   logic [23:0]        r_rgb;
   logic [COORD_W-1:0] r_h_cnt, r_h_meas, r_x_cnt, r_ha_meas, r_line_cnt, r_y_cnt;
   logic               r_first_line, r_line_err;

   logic               w_hs_edge, w_vs_edge, w_blank_fall, w_h_sat, w_line_bad;
   logic [COORD_W-1:0] w_h_next;

   assign w_hs_edge    = r_hs_a & ~r_hs_d;
   assign w_vs_edge    = r_vs_a & ~r_vs_d;
   assign w_blank_fall = r_blank_d & ~r_blank;
   assign w_h_next     = r_h_cnt + C_ONE;
   assign w_h_sat      = &r_h_cnt;
   // The first line closed after a VS edge straddles the frame boundary and
   // is not compared against the previous frame's last line.
   assign w_line_bad   = w_hs_edge & ~r_first_line & (w_h_next != r_h_meas);

   assign o_blank    = r_blank;
   assign o_rgb      = r_rgb;
   assign o_hs_edge  = w_hs_edge;
   assign o_vs_edge  = w_vs_edge;
   assign o_x        = w_hs_edge ? '0 : r_x_cnt;
   assign o_y        = r_y_cnt;
   // Same-cycle HS edge / blank fall are folded in so the VS evaluation sees
   // the line that is being closed in this very cycle.
   assign o_h_meas   = w_hs_edge ? w_h_next : r_h_meas;
   assign o_ha_meas  = w_blank_fall ? r_x_cnt : r_ha_meas;
   assign o_v_meas   = w_hs_edge ? r_line_cnt + C_ONE : r_line_cnt;
   assign o_va_meas  = w_blank_fall ? r_y_cnt + C_ONE : r_y_cnt;
   assign o_line_err = r_line_err | w_line_bad;
   assign o_wdog     = w_h_sat & ~w_hs_edge;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_hs_a       <= 1'b0;
         r_vs_a       <= 1'b0;
         r_blank      <= 1'b0;
         r_hs_d       <= 1'b0;
         r_vs_d       <= 1'b0;
         r_blank_d    <= 1'b0;
         r_rgb        <= '0;
         r_h_cnt      <= '0;
         r_h_meas     <= '0;
         r_x_cnt      <= '0;
         r_ha_meas    <= '0;
         r_line_cnt   <= '0;
         r_y_cnt      <= '0;
         r_first_line <= 1'b1;
         r_line_err   <= 1'b0;
      end else begin
         r_hs_a    <= i_hs ^ HS_ACTIVE_LOW;
         r_vs_a    <= i_vs ^ VS_ACTIVE_LOW;
         r_blank   <= i_blank_n;
         r_rgb     <= i_rgb;
         r_hs_d    <= r_hs_a;
         r_vs_d    <= r_vs_a;
         r_blank_d <= r_blank;

         if (w_hs_edge) begin
            r_h_cnt  <= '0;
            r_h_meas <= w_h_next;
         end else if (!w_h_sat) begin
            r_h_cnt  <= w_h_next;
         end

         if (w_hs_edge)    r_x_cnt <= {{(COORD_W-1){1'b0}}, r_blank};
         else if (r_blank) r_x_cnt <= r_x_cnt + C_ONE;
         if (w_blank_fall) r_ha_meas <= r_x_cnt;

         // HS is processed before VS, so a coincident VS edge wins the reset.
         if (w_vs_edge) begin
            r_line_cnt   <= '0;
            r_y_cnt      <= '0;
            r_first_line <= 1'b1;
            r_line_err   <= 1'b0;
         end else begin
            if (w_hs_edge)    r_line_cnt   <= r_line_cnt + C_ONE;
            if (w_hs_edge)    r_first_line <= 1'b0;
            if (w_blank_fall) r_y_cnt      <= r_y_cnt + C_ONE;
            if (w_line_bad)   r_line_err   <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: VGA receiver that measures frame geometry, locks onto a
// stable timing and emits active-area pixels with coordinates.
//   vga_clk, reset                 - clock, synchronous active-high reset
//   blank_n, HS, VS, red/green/blue - incoming VGA stream
//   pixel_valid/x/y/rgb            - visible pixel, only while locked
//   line_start, frame_start        - one-cycle sync assertion pulses
//   locked                         - geometry stable for LOCK_FRAMES frames
//   h_total..v_active              - last committed geometry
// All outputs trail the inputs by exactly two clocks.
module vga_sync_decoder
   import vga_rx_pkg::*;
#(
   parameter int COORD_W       = COORD_W_DEFAULT,
   parameter int LOCK_FRAMES   = 2,
   parameter bit HS_ACTIVE_LOW = 1'b1,
   parameter bit VS_ACTIVE_LOW = 1'b1
) (
   input  logic               vga_clk,
   input  logic               reset,
   input  logic               blank_n,
   input  logic               HS,
   input  logic               VS,
   input  logic [7:0]         red,
   input  logic [7:0]         green,
   input  logic [7:0]         blue,
   output logic               pixel_valid,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic [23:0]        pixel_rgb,
   output logic               line_start,
   output logic               frame_start,
   output logic               locked,
   output logic [COORD_W-1:0] h_total,
   output logic [COORD_W-1:0] h_active,
   output logic [COORD_W-1:0] v_total,
   output logic [COORD_W-1:0] v_active
);
   typedef struct packed {
      logic [COORD_W-1:0] h_total;
      logic [COORD_W-1:0] h_active;
      logic [COORD_W-1:0] v_total;
      logic [COORD_W-1:0] v_active;
   } meas_t;

   logic               w_blank, w_hs_edge, w_vs_edge, w_line_err, w_wdog, w_same;
   logic [23:0]        w_rgb;
   logic [COORD_W-1:0] w_x, w_y, w_h_meas, w_ha_meas, w_v_meas, w_va_meas;
   logic [3:0]         w_cnt_inc;
   meas_t              w_meas;

   rx_state_t          r_state;
   logic               r_prev_valid;
   logic [3:0]         r_match_cnt;
   meas_t              r_stored;

   vga_rx_counters #(
      .COORD_W       (COORD_W),
      .HS_ACTIVE_LOW (HS_ACTIVE_LOW),
      .VS_ACTIVE_LOW (VS_ACTIVE_LOW)
   ) u_cnt (
      .vga_clk    (vga_clk),
      .reset      (reset),
      .i_blank_n  (blank_n),
      .i_hs       (HS),
      .i_vs       (VS),
      .i_rgb      ({red, green, blue}),
      .o_blank    (w_blank),
      .o_rgb      (w_rgb),
      .o_hs_edge  (w_hs_edge),
      .o_vs_edge  (w_vs_edge),
      .o_x        (w_x),
      .o_y        (w_y),
      .o_h_meas   (w_h_meas),
      .o_ha_meas  (w_ha_meas),
      .o_v_meas   (w_v_meas),
      .o_va_meas  (w_va_meas),
      .o_line_err (w_line_err),
      .o_wdog     (w_wdog)
   );

   assign w_meas    = {w_h_meas, w_ha_meas, w_v_meas, w_va_meas};
   assign w_same    = r_prev_valid & ~w_line_err & (w_meas == r_stored);
   assign w_cnt_inc = r_match_cnt + 4'd1;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_state      <= SEARCH;
         r_prev_valid <= 1'b0;
         r_match_cnt  <= '0;
         r_stored     <= '0;
         pixel_valid  <= 1'b0;
         pixel_x      <= '0;
         pixel_y      <= '0;
         pixel_rgb    <= '0;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         locked       <= 1'b0;
         {h_total, h_active, v_total, v_active} <= '0;
      end else begin
         line_start  <= w_hs_edge;
         frame_start <= w_vs_edge;
         pixel_valid <= w_blank & (r_state == LOCKED);
         if (w_blank && r_state == LOCKED) begin
            pixel_x   <= w_x;
            pixel_y   <= w_y;
            pixel_rgb <= w_rgb;
         end

         // A dead HS overrides any VS decision in the same cycle.
         if (w_wdog) begin
            r_state <= SEARCH;
            locked  <= 1'b0;
         end else if (w_vs_edge) begin
            case (r_state)
               SEARCH: begin
                  // Partial frame since reset/loss is not trusted.
                  r_state      <= ACQUIRE;
                  r_prev_valid <= 1'b0;
                  r_match_cnt  <= '0;
               end
               ACQUIRE: begin
                  r_stored     <= w_meas;
                  r_prev_valid <= 1'b1;
                  if (w_same) begin
                     r_match_cnt <= w_cnt_inc;
                     if (w_cnt_inc == 4'(LOCK_FRAMES)) begin
                        r_state <= LOCKED;
                        locked  <= 1'b1;
                        {h_total, h_active, v_total, v_active} <= w_meas;
                     end
                  end else begin
                     r_match_cnt <= '0;
                  end
               end
               LOCKED: begin
                  r_stored     <= w_meas;
                  r_prev_valid <= 1'b1;
                  if (!w_same) begin
                     r_state     <= ACQUIRE;
                     locked      <= 1'b0;
                     r_match_cnt <= '0;
                  end
               end
               default: r_state <= SEARCH;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_vga_sync_decoder.sv
module tb_vga_sync_decoder;
   logic        clk = 1'b0;
   logic        rst, bl, hs, vs, hs1, vs1;
   logic [7:0]  r, g, b;

   logic        pv [2];
   logic [10:0] px [2];
   logic [10:0] py [2];
   logic [23:0] prgb [2];
   logic        ls [2];
   logic        fs [2];
   logic        lk [2];
   logic [10:0] ht [2];
   logic [10:0] ha [2];
   logic [10:0] vt [2];
   logic [10:0] va [2];

   int n_chk = 0;
   int n_fail = 0;

   // per-frame statistics, one slot per DUT
   logic lk0 [2];
   logic lk1 [2];
   int   npix [2];
   int   nerr [2];
   int   nls [2];
   int   nfs [2];

   // stimulus driven in the previous cycle (what the outputs show now)
   logic        pb;
   logic [10:0] pxv, pyv;
   logic [23:0] prgbv;

   always #5 clk = ~clk;

   vga_sync_decoder u_dut0 (
      .vga_clk(clk), .reset(rst), .blank_n(bl), .HS(hs), .VS(vs),
      .red(r), .green(g), .blue(b),
      .pixel_valid(pv[0]), .pixel_x(px[0]), .pixel_y(py[0]), .pixel_rgb(prgb[0]),
      .line_start(ls[0]), .frame_start(fs[0]), .locked(lk[0]),
      .h_total(ht[0]), .h_active(ha[0]), .v_total(vt[0]), .v_active(va[0])
   );

   vga_sync_decoder #(.HS_ACTIVE_LOW(1'b0), .VS_ACTIVE_LOW(1'b0)) u_dut1 (
      .vga_clk(clk), .reset(rst), .blank_n(bl), .HS(hs1), .VS(vs1),
      .red(r), .green(g), .blue(b),
      .pixel_valid(pv[1]), .pixel_x(px[1]), .pixel_y(py[1]), .pixel_rgb(prgb[1]),
      .line_start(ls[1]), .frame_start(fs[1]), .locked(lk[1]),
      .h_total(ht[1]), .h_active(ha[1]), .v_total(vt[1]), .v_active(va[1])
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] outs(input int d);
      return {34'd0, pv[d], px[d], py[d], prgb[d], ls[d], fs[d], lk[d],
              ht[d], ha[d], vt[d], va[d]};
   endfunction

   function automatic logic [43:0] geo(input int d);
      return {ht[d], ha[d], vt[d], va[d]};
   endfunction

   // One pixel clock. Line: sync 0-3, back porch, active (hav wide) ending at 27,
   // front porch to end. Frame: VS lines 0-1, active lines 6-13.
   task automatic step(input int l, input int c, input int hav, input int n);
      int          a0;
      logic        act;
      logic [10:0] xv, yv;
      logic [23:0] rgbv;
      a0   = 28 - hav;
      act  = (l >= 6) && (l < 14) && (c >= a0) && (c < 28);
      xv   = 11'(c - a0);
      yv   = 11'(l - 6);
      rgbv = act ? {xv[7:0], yv[7:0], 8'hA5} : 24'($urandom);
      hs = (c >= 4); vs = (l >= 2); hs1 = ~hs; vs1 = ~vs; bl = act;
      {r, g, b} = rgbv;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         if (n == 0) lk0[d] = lk[d];
         if (n == 1) lk1[d] = lk[d];
         if (pv[d]) npix[d]++;
         if (ls[d]) nls[d]++;
         if (fs[d]) nfs[d]++;
         if (pv[d] !== pb || (pb && (px[d] !== pxv || py[d] !== pyv || prgb[d] !== prgbv)))
            nerr[d]++;
      end
      pb = act; pxv = xv; pyv = yv; prgbv = rgbv;
   endtask

   // jit: line index stretched to 33 clocks (-1 for none);
   // only clocks skip..lim-1 of the frame are driven.
   task automatic frame(input int hav, input int jit, input int skip, input int lim);
      int n;
      n = 0;
      for (int d = 0; d < 2; d++) begin
         npix[d] = 0; nerr[d] = 0; nls[d] = 0; nfs[d] = 0;
      end
      for (int l = 0; l < 16; l++) begin
         for (int c = 0; c < ((l == jit) ? 33 : 32); c++) begin
            if (n >= skip && n < lim) step(l, c, hav, n - skip);
            n++;
         end
      end
   endtask

   task automatic hold(input int n, input logic blv);
      hs = 1'b1; vs = 1'b1; hs1 = 1'b0; vs1 = 1'b0; bl = blv; {r, g, b} = 24'h0;
      repeat (n) begin @(posedge clk); #1; end
      pb = blv;
   endtask

   initial begin
      pb = 1'b0; pxv = '0; pyv = '0; prgbv = '0;
      rst = 1'b1;
      hold(3, 1'b0);
      for (int d = 0; d < 2; d++) chk($sformatf("reset_state%0d", d), outs(d), 128'd0);
      rst = 1'b0;

      // lock-up: reset released mid-line 8, then full frames
      frame(16, -1, 8*32 + 17, 9999);
      frame(16, -1, 0, 9999);                 // VS edge 1 at start
      frame(16, -1, 0, 9999);                 // edge 2
      frame(16, -1, 0, 9999);                 // edge 3
      for (int d = 0; d < 2; d++) chk($sformatf("lock_early%0d", d), 128'(lk1[d]), 128'd0);
      frame(16, -1, 0, 9999);                 // edge 4 -> lock
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("lock_pre%0d", d), 128'(lk0[d]), 128'd0);
         chk($sformatf("lock_rise%0d", d), 128'(lk1[d]), 128'd1);
         chk($sformatf("geometry%0d", d), 128'(geo(d)), 128'({11'd32, 11'd16, 11'd16, 11'd8}));
         chk($sformatf("pix_count%0d", d), 128'(npix[d]), 128'd128);
         chk($sformatf("pix_coord%0d", d), 128'(nerr[d]), 128'd0);
      end

      // coordinates in a fully locked frame
      frame(16, -1, 0, 9999);
      chk("stay_locked", 128'({lk0[0], lk1[0]}), 128'd3);
      chk("pix_count_f5", 128'(npix[0]), 128'd128);
      chk("pix_coord_f5", 128'(nerr[0]), 128'd0);
      chk("line_pulses", 128'(nls[0]), 128'd16);
      chk("frame_pulses", 128'(nfs[0]), 128'd1);

      // geometry change to 17 active columns
      frame(17, -1, 0, 9999);
      frame(17, -1, 0, 9999);
      chk("geo_drop", 128'({lk0[0], lk1[0]}), 128'd2);
      chk("geo_hold", 128'(geo(0)), 128'({11'd32, 11'd16, 11'd16, 11'd8}));
      frame(17, -1, 0, 9999);
      chk("geo_nolock", 128'(lk1[0]), 128'd0);
      frame(17, -1, 0, 9999);
      chk("geo_relock", 128'({lk0[0], lk1[0]}), 128'd1);
      chk("geo_new", 128'(geo(0)), 128'({11'd32, 11'd17, 11'd16, 11'd8}));

      // back to 16 wide, then one stretched line
      frame(16, -1, 0, 9999);
      frame(16, -1, 0, 9999);
      frame(16, -1, 0, 9999);
      frame(16, -1, 0, 9999);
      chk("relock16", 128'(lk1[0]), 128'd1);
      frame(16, 4, 0, 9999);
      chk("pre_jitter", 128'(lk1[0]), 128'd1);
      frame(16, -1, 0, 9999);
      chk("jitter_drop", 128'({lk0[0], lk1[0]}), 128'd2);
      frame(16, -1, 0, 9999);
      frame(16, -1, 0, 9999);
      chk("relock_jit", 128'(lk1[0]), 128'd1);

      // watchdog: no HS for more than 2^11 clocks, blank_n held high
      hold(2100, 1'b1);
      chk("wd_locked", 128'(lk[0]), 128'd0);
      chk("wd_pv", 128'(pv[0]), 128'd0);
      frame(16, -1, 0, 9999);                 // edge 1 out of SEARCH
      frame(16, -1, 0, 9999);
      frame(16, -1, 0, 9999);
      chk("wd_search", 128'(lk1[0]), 128'd0);
      frame(16, -1, 0, 9999);
      chk("wd_relock", 128'({lk0[0], lk1[0]}), 128'd1);

      // reset mid-frame in the active area
      frame(16, -1, 0, 8*32 + 20);
      chk("pre_reset_pv", 128'(pv[0]), 128'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) chk($sformatf("mid_reset%0d", d), outs(d), 128'd0);
      rst = 1'b0;
      frame(16, -1, 0, 9999);
      frame(16, -1, 0, 9999);
      frame(16, -1, 0, 9999);
      chk("rst_nolock", 128'(lk1[0]), 128'd0);
      frame(16, -1, 0, 9999);
      chk("rst_relock", 128'({lk0[0], lk1[0]}), 128'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
